// File: rtl/rmii_rx_framer_if.sv
// RMII receive pins plus the framed byte stream handed to the header/payload parser.
interface rmii_rx_framer_if;
  logic [1:0] rmii_rxd;
  logic       rmii_crs_dv;
  logic       rmii_rx_er;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       out_eof;
  logic       out_err;
  logic       rx_active;

  modport master (
    input  rmii_rxd, rmii_crs_dv, rmii_rx_er,
    output out_data, out_valid, out_sof, out_eof, out_err, rx_active
  );

  modport slave (
    output rmii_rxd, rmii_crs_dv, rmii_rx_er,
    input  out_data, out_valid, out_sof, out_eof, out_err, rx_active
  );
endinterface

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD and emits LSB-dibit-first bytes with one byte held
// back so the final byte of each frame can carry the end-of-frame and error markers.
module rmii_rx_framer #(
  parameter int PREAMBLE_MIN    = 8,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input logic               clk,
  input logic               rst_n,
  rmii_rx_framer_if.master  bus
);

  localparam int PRE_W = $clog2(PREAMBLE_MIN + 1);
  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(PREAMBLE_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]       r_rxd_q;
  logic             r_dv_q;
  logic             r_er_q;
  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [1:0]       r_dibit_idx;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_hold;
  logic             r_hold_vld;
  logic             r_hold_first;
  logic             r_err_sticky;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_sof;
  logic             r_out_eof;
  logic             r_out_err;
  logic             r_rx_active;
  logic [7:0]       w_byte;

  assign w_byte = {r_rxd_q, r_shift[7:2]};

  // Single input register stage; every decision below uses these sampled copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_q <= 2'b00;
      r_dv_q  <= 1'b0;
      r_er_q  <= 1'b0;
    end else begin
      r_rxd_q <= bus.rmii_rxd;
      r_dv_q  <= bus.rmii_crs_dv;
      r_er_q  <= bus.rmii_rx_er;
    end
  end

  // Frame state machine, byte assembly, hold register and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pre_cnt    <= {PRE_W{1'b0}};
      r_dibit_idx  <= 2'd0;
      r_byte_cnt   <= {CNT_W{1'b0}};
      r_shift      <= 8'h00;
      r_hold       <= 8'h00;
      r_hold_vld   <= 1'b0;
      r_hold_first <= 1'b0;
      r_err_sticky <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_out_err    <= 1'b0;
      r_rx_active  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_dv_q) begin
            r_state   <= S_PRE;
            r_pre_cnt <= {PRE_W{1'b0}};
          end
        end
        S_PRE: begin
          if (!r_dv_q) begin
            r_state <= S_IDLE;
          end else begin
            case (r_rxd_q)
              2'b01: begin
                if (r_pre_cnt < PRE_SAT) r_pre_cnt <= r_pre_cnt + PRE_W'(1);
              end
              2'b00: r_pre_cnt <= {PRE_W{1'b0}};
              2'b11: begin
                if (r_pre_cnt >= PRE_SAT) begin
                  r_state      <= S_DATA;
                  r_rx_active  <= 1'b1;
                  r_dibit_idx  <= 2'd0;
                  r_byte_cnt   <= {CNT_W{1'b0}};
                  r_err_sticky <= 1'b0;
                  r_hold_vld   <= 1'b0;
                end else begin
                  r_state <= S_DROP;
                end
              end
              default: r_state <= S_DROP;
            endcase
          end
        end
        S_DATA: begin
          if (!r_dv_q) begin
            // Carrier gone: flush the held byte as the frame's last byte.
            r_state     <= S_IDLE;
            r_rx_active <= 1'b0;
            r_hold_vld  <= 1'b0;
            if (r_hold_vld) begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_hold;
              r_out_sof   <= r_hold_first;
              r_out_eof   <= 1'b1;
              r_out_err   <= r_err_sticky | (r_dibit_idx != 2'd0);
            end
          end else begin
            r_shift     <= w_byte;
            r_dibit_idx <= r_dibit_idx + 2'd1;
            if (r_er_q) r_err_sticky <= 1'b1;
            if (r_dibit_idx == 2'd3) begin
              if (r_byte_cnt == CNT_MAX) begin
                // Oversize frame: close it on the held byte and discard the rest.
                r_state     <= S_DROP;
                r_rx_active <= 1'b0;
                r_hold_vld  <= 1'b0;
                r_out_valid <= r_hold_vld;
                r_out_data  <= r_hold;
                r_out_sof   <= r_hold_first & r_hold_vld;
                r_out_eof   <= r_hold_vld;
                r_out_err   <= r_hold_vld;
              end else begin
                if (r_hold_vld) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_hold;
                  r_out_sof   <= r_hold_first;
                end
                r_hold       <= w_byte;
                r_hold_vld   <= 1'b1;
                r_hold_first <= (r_byte_cnt == {CNT_W{1'b0}});
                r_byte_cnt   <= r_byte_cnt + CNT_W'(1);
              end
            end
          end
        end
        S_DROP: begin
          if (!r_dv_q) r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rx_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sof   = r_out_sof;
  assign bus.out_eof   = r_out_eof;
  assign bus.out_err   = r_out_err;
  assign bus.rx_active = r_rx_active;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer; MAX_FRAME_BYTES is set to 4 so truncation is reachable.
module tb_rmii_rx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rmii_rx_framer_if bif ();

  rmii_rx_framer #(.PREAMBLE_MIN(8), .MAX_FRAME_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } strobe_t;

  strobe_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  // Record every output strobe for later comparison.
  always @(negedge clk) begin
    if (bif.out_valid === 1'b1) q.push_back({bif.out_data, bif.out_sof, bif.out_eof, bif.out_err});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobe(input string tag, input int i, input logic [7:0] d,
                            input logic sof, input logic eof, input logic err);
    if (i < q.size()) begin
      chk({tag, "_data"}, 32'(q[i].d), 32'(d));
      chk({tag, "_sof"},  32'(q[i].sof), 32'(sof));
      chk({tag, "_eof"},  32'(q[i].eof), 32'(eof));
      chk({tag, "_err"},  32'(q[i].err), 32'(err));
    end else begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed strobe count %0d, required strobe index %0d", tag, q.size(), i);
    end
  endtask

  task automatic dibit(input logic [1:0] d, input logic er);
    @(negedge clk);
    bif.rmii_rxd    = d;
    bif.rmii_crs_dv = 1'b1;
    bif.rmii_rx_er  = er;
  endtask

  task automatic send_byte(input logic [7:0] b, input int er_at);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] t;
      t = b >> (2 * k);
      dibit(t[1:0], (k == er_at) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic preamble(input int n01);
    for (int k = 0; k < n01; k++) dibit(2'b01, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bif.rmii_rxd    = 2'b00;
      bif.rmii_crs_dv = 1'b0;
      bif.rmii_rx_er  = 1'b0;
    end
  endtask

  task automatic good_frame_start();
    preamble(31);
    dibit(2'b11, 1'b0);
  endtask

  initial begin
    bif.rmii_rxd    = 2'b00;
    bif.rmii_crs_dv = 1'b0;
    bif.rmii_rx_er  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid",  32'(bif.out_valid), 32'd0);
    chk("rst_data",   32'(bif.out_data),  32'd0);
    chk("rst_sof",    32'(bif.out_sof),   32'd0);
    chk("rst_eof",    32'(bif.out_eof),   32'd0);
    chk("rst_err",    32'(bif.out_err),   32'd0);
    chk("rst_active", 32'(bif.rx_active), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Test 1: basic three-byte frame
    preamble(31);
    chk("t1_active_pre", 32'(bif.rx_active), 32'd0);
    dibit(2'b11, 1'b0);
    send_byte(8'h01, -1);
    chk("t1_active_data", 32'(bif.rx_active), 32'd1);
    send_byte(8'h02, -1);
    send_byte(8'h03, -1);
    chk("t1_active_last", 32'(bif.rx_active), 32'd1);
    idle(6);
    chk("t1_active_idle", 32'(bif.rx_active), 32'd0);
    chk("t1_count", 32'(q.size()), 32'd3);
    chk_strobe("t1_b0", 0, 8'h01, 1'b1, 1'b0, 1'b0);
    chk_strobe("t1_b1", 1, 8'h02, 1'b0, 1'b0, 1'b0);
    chk_strobe("t1_b2", 2, 8'h03, 1'b0, 1'b1, 1'b0);
    q.delete();

    // Test 2: rx_er during the second byte flags the frame on its eof byte
    good_frame_start();
    send_byte(8'h01, -1);
    send_byte(8'h02, 1);
    send_byte(8'h03, -1);
    idle(6);
    chk("t2_count", 32'(q.size()), 32'd3);
    chk_strobe("t2_b0", 0, 8'h01, 1'b1, 1'b0, 1'b0);
    chk_strobe("t2_b1", 1, 8'h02, 1'b0, 1'b0, 1'b0);
    chk_strobe("t2_b2", 2, 8'h03, 1'b0, 1'b1, 1'b1);
    q.delete();

    // Test 3: short preamble is dropped, next frame is fine
    preamble(3);
    dibit(2'b11, 1'b0);
    send_byte(8'h01, -1);
    send_byte(8'h02, -1);
    chk("t3_active_drop", 32'(bif.rx_active), 32'd0);
    idle(6);
    chk("t3_count_drop", 32'(q.size()), 32'd0);
    good_frame_start();
    send_byte(8'h01, -1);
    send_byte(8'h02, -1);
    send_byte(8'h03, -1);
    idle(6);
    chk("t3_count_good", 32'(q.size()), 32'd3);
    chk_strobe("t3_b0", 0, 8'h01, 1'b1, 1'b0, 1'b0);
    chk_strobe("t3_b2", 2, 8'h03, 1'b0, 1'b1, 1'b0);
    q.delete();

    // Test 4: alignment error on a one-byte frame
    good_frame_start();
    send_byte(8'hAA, -1);
    dibit(2'b01, 1'b0);
    dibit(2'b10, 1'b0);
    idle(6);
    chk("t4_count", 32'(q.size()), 32'd1);
    chk_strobe("t4_b0", 0, 8'hAA, 1'b1, 1'b1, 1'b1);
    q.delete();

    // Test 5: oversize frame truncated at four bytes, following frame starts clean
    good_frame_start();
    for (int b = 0; b < 6; b++) send_byte(8'(8'h10 + b), -1);
    chk("t5_active_drop", 32'(bif.rx_active), 32'd0);
    idle(6);
    chk("t5_count", 32'(q.size()), 32'd4);
    chk_strobe("t5_b0", 0, 8'h10, 1'b1, 1'b0, 1'b0);
    chk_strobe("t5_b1", 1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk_strobe("t5_b2", 2, 8'h12, 1'b0, 1'b0, 1'b0);
    chk_strobe("t5_b3", 3, 8'h13, 1'b0, 1'b1, 1'b1);
    q.delete();
    good_frame_start();
    send_byte(8'h21, -1);
    idle(6);
    chk("t5_next_count", 32'(q.size()), 32'd1);
    chk_strobe("t5_next", 0, 8'h21, 1'b1, 1'b1, 1'b0);
    q.delete();

    // Test 6: reset mid-payload abandons the frame silently
    good_frame_start();
    send_byte(8'h31, -1);
    dibit(2'b10, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",  32'(bif.out_valid), 32'd0);
    chk("t6_rst_data",   32'(bif.out_data),  32'd0);
    chk("t6_rst_eof",    32'(bif.out_eof),   32'd0);
    chk("t6_rst_active", 32'(bif.rx_active), 32'd0);
    dibit(2'b00, 1'b0);
    dibit(2'b00, 1'b0);
    rst_n = 1'b1;
    send_byte(8'h33, -1);
    send_byte(8'h33, -1);
    idle(6);
    chk("t6_abort_count", 32'(q.size()), 32'd0);
    good_frame_start();
    send_byte(8'h41, -1);
    send_byte(8'h42, -1);
    idle(6);
    chk("t6_next_count", 32'(q.size()), 32'd2);
    chk_strobe("t6_b0", 0, 8'h41, 1'b1, 1'b0, 1'b0);
    chk_strobe("t6_b1", 1, 8'h42, 1'b0, 1'b1, 1'b0);
    q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
